maxpool_serializer: RTL and testbench
=====================================

Name: maxpool_serializer

Overview:
- Sits directly downstream of the convolutional layer.
- Accepts one N_CHANNELS-wide result vector per input handshake and computes a per-channel signed max over POOL_SIZE consecutive vectors, with optional ReLU.
- Serializes the pooled vector one word per output handshake, channel 0 first, into the next layer's single-word demanding input.

Parameters:
- N_CHANNELS, 256: number of channels (parallel words per input vector).
- WORD_SIZE, 16: bits per word, two's-complement fixed point.
- POOL_SIZE, 2: input vectors pooled per output group; must be ≥1.
- RELU_EN, 1: 1 clamps negative pooled values to 0 at output; 0 passes them through.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  upstream vector valid.
- ready_o  out  1  block can accept a vector.
- data_i  in  [N_CHANNELS-1:0][WORD_SIZE-1:0]  input vector; word c is channel c, signed.
- valid_o  out  1  data_o holds a pooled word.
- yumi_i  in  1  downstream consumes data_o this cycle; legal only while valid_o=1.
- data_o  out  WORD_SIZE  pooled word of the current channel.

Behaviour:
- Clocking and reset: one clock. reset_i is asynchronous and active-high and clears all state immediately.
- Reset values:
  - state = eACCUM; ready_o = 1; valid_o = 0; data_o = 0.
  - pool_cnt = 0; chan_idx = 0; max_r = all 0.
- Input handshake: hs_in = valid_i & ready_o. Output handshake: hs_out = valid_o & yumi_i.
- The FSM has two states, eACCUM and eDRAIN.
- eACCUM:
  - ready_o = 1; valid_o = 0; data_o = 0.
  - On hs_in with pool_cnt==0: max_r[c] <= data_i[c] for every c. Stale values from the previous group are never compared.
  - On hs_in with pool_cnt>0: max_r[c] <= signed max(max_r[c], data_i[c]).
  - On hs_in, pool_cnt increments. When pool_cnt==POOL_SIZE-1: pool_cnt <= 0, chan_idx <= 0, next state = eDRAIN.
  - With no hs_in, all registers hold.
- eDRAIN:
  - ready_o = 0; valid_o = 1.
  - data_o = max_r[chan_idx]. If RELU_EN and the MSB is 1, data_o = 0.
  - data_o is driven combinationally from registers and stays stable while yumi_i is low.
  - On hs_out: chan_idx increments. When chan_idx==N_CHANNELS-1: chan_idx <= 0, next state = eACCUM.
  - valid_i is ignored in this state; there is no overlap of input and drain.
- Latency:
  - valid_o rises the cycle after the POOL_SIZE-th hs_in.
  - ready_o rises the cycle after the final hs_out.
  - Minimum period per group = POOL_SIZE + N_CHANNELS cycles.
- POOL_SIZE=1: the block is a pure parallel-to-serial converter (plus ReLU).
- Comparison: full-width signed. Ties keep the stored value (result is identical). No saturation is needed.
- Boundaries:
  - yumi_i while valid_o=0 has no effect.
  - Counter widths are $clog2 of their terminal count, with a minimum width of 1.
  - Wrap-around happens only via the explicit terminal compares above.
  - Reset asserted mid-accumulate or mid-drain discards the partial group. The next group after release starts with pool_cnt=0 and chan_idx=0.

Decomposition:
- Shared package cnn_pkg:
  - state typedef enum logic {eACCUM, eDRAIN}.
  - Function signed_max(a, b) for WORD_SIZE-wide operands.
  - Function relu(x, en).
- One sub-module, mod_counter #(MAX): async-reset up-counter with en_i, terminal flag, and wrap to 0. Instantiated for pool_cnt and chan_idx.
- The max_r array and the output mux remain in the top module.

Test Plan (N_CHANNELS=4, WORD_SIZE=16, POOL_SIZE=2 unless noted):
1. Reset: assert reset_i mid-cycle with no clock edge → valid_o=0, ready_o=1, data_o=0 immediately.
2. Pooling, RELU_EN=0:
   - Send {0x1000, 0xE000, 0x3000, 0xC000} then {0x2000, 0xB000, 0x1000, 0xF000}.
   - Required: data_o = 0x2000, 0xE000, 0x3000, 0xF000 on four hs_out.
   - ready_o=0 throughout the drain.
3. Same stimulus with RELU_EN=1 → data_o = 0x2000, 0x0000, 0x3000, 0x0000.
4. Backpressure:
   - Hold yumi_i=0 for 3 cycles after valid_o rises → data_o stays 0x2000 and chan_idx stays 0.
   - Hold valid_i=1 during the drain → no vector is consumed until the cycle after the 4th hs_out.
5. Reset mid-drain:
   - Assert reset_i after 2 hs_out → valid_o=0 at once.
   - Then send {5,5,5,5}, {1,1,1,1} → outputs 5,5,5,5. No residual channels are emitted.
6. Signed extremes, with POOL_SIZE=3 and RELU_EN=0:
   - Send channel 0 = 0x8000, 0x7FFF, 0x7FFF → 0x7FFF.
   - Send channel 1 all 0x8000 → 0x8000.
   - Required: valid_o rises exactly 1 cycle after the 3rd hs_in.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and helpers for the CNN datapath blocks.
//   state_e    : pooling/serializing FSM states.
//   calc_t     : wide signed carrier; callers sign-extend words into it and
//                truncate results back, so one helper serves any WORD_SIZE
//                up to CALC_W bits.
//   signed_max : signed maximum; on a tie the first operand (stored value) wins.
//   relu       : clamps negative values to zero when en is set.
package cnn_pkg;

  typedef enum logic {eACCUM, eDRAIN} state_e;

  localparam int unsigned CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic calc_t signed_max(input calc_t a, input calc_t b);
    return (b > a) ? b : a;
  endfunction

  function automatic calc_t relu(input calc_t x, input logic en);
    return (en && x[CALC_W-1]) ? '0 : x;
  endfunction

endpackage

// File: rtl/maxpool_serializer_if.sv
// maxpool_serializer_if: vector-in / word-out handshake bundle.
//   valid_i/ready_o/data_i : upstream vector handshake (N_CHANNELS words).
//   valid_o/yumi_i/data_o  : downstream single-word valid/yumi handshake.
//   slave  : block side.  master : producer/consumer side.
interface maxpool_serializer_if #(
  parameter int unsigned N_CHANNELS = 256,
  parameter int unsigned WORD_SIZE  = 16
);
  logic                                 valid_i;
  logic                                 ready_o;
  logic [N_CHANNELS-1:0][WORD_SIZE-1:0] data_i;
  logic                                 valid_o;
  logic                                 yumi_i;
  logic [WORD_SIZE-1:0]                 data_o;

  modport slave  (input  valid_i, data_i, yumi_i,
                  output ready_o, valid_o, data_o);
  modport master (output valid_i, data_i, yumi_i,
                  input  ready_o, valid_o, data_o);
endinterface

// File: rtl/maxpool_serializer_mod_counter.sv
// mod_counter: modulo-MAX up-counter with asynchronous active-high reset.
//   clk_i   : clock, rising edge.
//   reset_i : asynchronous active-high reset (count -> 0).
//   en_i    : advance by one this cycle.
//   cnt_o   : current count, 0 .. MAX-1.
//   last_o  : count equals MAX-1; an enabled advance wraps to 0.
module mod_counter #(
  parameter  int unsigned MAX = 2,
  localparam int unsigned W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == W'(MAX - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = last_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/maxpool_serializer.sv
// maxpool_serializer: per-channel signed max over POOL_SIZE input vectors,
// optional ReLU, then one word per output handshake, channel 0 first.
//   clk_i   : clock, rising edge.
//   reset_i : asynchronous active-high reset; discards any partial group.
//   bus_if  : slave side of maxpool_serializer_if
//             (valid_i/ready_o/data_i in, valid_o/yumi_i/data_o out).
// Input and drain never overlap: ready_o is low for the whole drain.
module maxpool_serializer
  import cnn_pkg::*;
#(
  parameter int unsigned N_CHANNELS = 256,
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned POOL_SIZE  = 2,
  parameter int unsigned RELU_EN    = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  maxpool_serializer_if.slave  bus_if
);

  localparam int unsigned POOL_W = (POOL_SIZE  > 1) ? $clog2(POOL_SIZE)  : 1;
  localparam int unsigned CHAN_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  typedef logic [N_CHANNELS-1:0][WORD_SIZE-1:0] vec_t;

  state_e              state_q;
  logic                ready_q;
  logic                valid_q;
  vec_t                max_q, max_d;
  logic [POOL_W-1:0]   pool_cnt;
  logic                pool_last;
  logic [CHAN_W-1:0]   chan_idx;
  logic                chan_last;
  logic                hs_in;
  logic                hs_out;
  logic [WORD_SIZE-1:0] word_out;

  assign hs_in  = bus_if.valid_i & ready_q;
  assign hs_out = valid_q & bus_if.yumi_i;

  mod_counter #(.MAX(POOL_SIZE)) u_pool_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (hs_in),
    .cnt_o   (pool_cnt),
    .last_o  (pool_last)
  );

  mod_counter #(.MAX(N_CHANNELS)) u_chan_idx (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (hs_out),
    .cnt_o   (chan_idx),
    .last_o  (chan_last)
  );

  // Both counters wrap to 0 at their own terminal count, so each is already
  // 0 whenever the other phase begins.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eACCUM;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        eACCUM: if (hs_in && pool_last) begin
          state_q <= eDRAIN;
          ready_q <= 1'b0;
          valid_q <= 1'b1;
        end
        eDRAIN: if (hs_out && chan_last) begin
          state_q <= eACCUM;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= eACCUM;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // First vector of a group overwrites, so stale maxima are never compared.
  always_comb begin
    max_d = max_q;
    if (hs_in) begin
      for (int unsigned c = 0; c < N_CHANNELS; c++) begin
        if (pool_cnt == '0)
          max_d[c] = bus_if.data_i[c];
        else
          max_d[c] = WORD_SIZE'(signed_max(calc_t'($signed(max_q[c])),
                                           calc_t'($signed(bus_if.data_i[c]))));
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) max_q <= '0;
    else         max_q <= max_d;
  end

  always_comb begin
    word_out = '0;
    if (valid_q)
      word_out = WORD_SIZE'(relu(calc_t'($signed(max_q[chan_idx])), RELU_EN != 0));
  end

  assign bus_if.ready_o = ready_q;
  assign bus_if.valid_o = valid_q;
  assign bus_if.data_o  = word_out;

endmodule

// File: tb/tb_maxpool_serializer.sv
// tb_maxpool_serializer: randomized self-checking bench.
// DUT a (POOL 2, no ReLU) and DUT b (POOL 2, ReLU) run in lockstep on the
// same stimulus; DUT c (POOL 3, no ReLU) runs its own groups. Expected words
// come from a per-channel max over the queued group vectors.
module tb_maxpool_serializer;

  localparam int unsigned NC = 4;
  localparam int unsigned WS = 16;
  typedef logic [NC-1:0][WS-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maxpool_serializer_if #(.N_CHANNELS(NC), .WORD_SIZE(WS)) bus_a ();
  maxpool_serializer_if #(.N_CHANNELS(NC), .WORD_SIZE(WS)) bus_b ();
  maxpool_serializer_if #(.N_CHANNELS(NC), .WORD_SIZE(WS)) bus_c ();

  maxpool_serializer #(.N_CHANNELS(NC), .WORD_SIZE(WS), .POOL_SIZE(2), .RELU_EN(0))
    u_dut_a (.clk_i(clk), .reset_i(rst), .bus_if(bus_a));
  maxpool_serializer #(.N_CHANNELS(NC), .WORD_SIZE(WS), .POOL_SIZE(2), .RELU_EN(1))
    u_dut_b (.clk_i(clk), .reset_i(rst), .bus_if(bus_b));
  maxpool_serializer #(.N_CHANNELS(NC), .WORD_SIZE(WS), .POOL_SIZE(3), .RELU_EN(0))
    u_dut_c (.clk_i(clk), .reset_i(rst), .bus_if(bus_c));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] ref_word(input vec_t g[$], input int c, input bit relu_on);
    int m;
    m = $signed(g[0][c]);
    for (int i = 1; i < g.size(); i++)
      if ($signed(g[i][c]) > m) m = $signed(g[i][c]);
    if (relu_on && m < 0) m = 0;
    return 16'(m);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int c = 0; c < NC; c++) begin
      case ($urandom_range(0, 4))
        0:       v[c] = 16'h8000;
        1:       v[c] = 16'h7FFF;
        2:       v[c] = 16'h0000;
        default: v[c] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic drive_in(input int w, input logic v, input vec_t d);
    if (w == 0) begin
      bus_a.valid_i = v; bus_a.data_i = d;
      bus_b.valid_i = v; bus_b.data_i = d;
    end else begin
      bus_c.valid_i = v; bus_c.data_i = d;
    end
  endtask

  task automatic drive_yumi(input int w, input logic y);
    if (w == 0) begin bus_a.yumi_i = y; bus_b.yumi_i = y; end
    else bus_c.yumi_i = y;
  endtask

  function automatic logic out_valid(input int w);
    return (w == 0) ? bus_a.valid_o : bus_c.valid_o;
  endfunction

  function automatic logic out_ready(input int w);
    return (w == 0) ? bus_a.ready_o : bus_c.ready_o;
  endfunction

  task automatic check_idle(input int w, input string tag);
    check({tag, "_valid"}, out_valid(w), 0);
    check({tag, "_ready"}, out_ready(w), 1);
    if (w == 0) begin
      check({tag, "_a_data"}, bus_a.data_o, 0);
      check({tag, "_b_data"}, bus_b.data_o, 0);
      check({tag, "_b_valid"}, bus_b.valid_o, 0);
    end else begin
      check({tag, "_c_data"}, bus_c.data_o, 0);
    end
  endtask

  task automatic check_word(input int w, input vec_t g[$], input int c);
    if (w == 0) begin
      check("a_data", bus_a.data_o, ref_word(g, c, 1'b0));
      check("b_data", bus_b.data_o, ref_word(g, c, 1'b1));
    end else begin
      check("c_data", bus_c.data_o, ref_word(g, c, 1'b0));
    end
  endtask

  // Present one vector and hold it until the handshake edge has passed.
  task automatic send(input int w, input vec_t v, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      drive_in(w, 1'b0, '0);
      drive_yumi(w, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
    end
    drive_yumi(w, 1'b0);
    drive_in(w, 1'b1, v);
    t = 0;
    while (!out_ready(w) && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) check("ready_wait", 0, 1);
    @(posedge clk); #1;
    drive_in(w, 1'b0, '0);
  endtask

  // abort_at >= 0: reset after that many output handshakes.
  task automatic run_group(input int w, input vec_t g[$], input int first_stall,
                           input bit hold, input vec_t hold_vec, input int abort_at);
    int ps;
    int stall;
    ps = g.size();
    for (int p = 0; p < ps; p++) begin
      send(w, g[p], (p == 0) ? 0 : $urandom_range(0, 2));
      if (p < ps - 1) begin
        check("accum_valid", out_valid(w), 0);
        check("accum_ready", out_ready(w), 1);
      end
    end
    check("lat_valid", out_valid(w), 1);
    check("drain_ready", out_ready(w), 0);
    if (hold) drive_in(w, 1'b1, hold_vec);
    for (int c = 0; c < NC; c++) begin
      if (c == abort_at) begin
        #2 rst = 1'b1;
        #1 check_idle(w, "rst_drain");
        @(posedge clk); #1;
        rst = 1'b0;
        drive_in(w, 1'b0, '0);
        drive_yumi(w, 1'b0);
        return;
      end
      stall = (c == 0 && first_stall >= 0) ? first_stall : $urandom_range(0, 2);
      for (int k = 0; k <= stall; k++) begin
        check_word(w, g, c);
        check("drain_valid", out_valid(w), 1);
        check("drain_ready", out_ready(w), 0);
        if (k < stall) begin @(posedge clk); #1; end
      end
      drive_yumi(w, 1'b1);
      @(posedge clk); #1;
      drive_yumi(w, 1'b0);
    end
    check_idle(w, "post_drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t g[$];
    vec_t v1, v2, v3, nv;
    bit   hold, hold_next;

    drive_in(0, 1'b0, '0);
    drive_in(1, 1'b0, '0);
    drive_yumi(0, 1'b0);
    drive_yumi(1, 1'b0);

    // Reset applied between clock edges must take effect immediately.
    #2 rst = 1'b1;
    #1 check_idle(0, "rst_init");
    check_idle(1, "rst_init");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed pooling, ReLU on/off, backpressure and valid held in drain.
    v1[0] = 16'h1000; v1[1] = 16'hE000; v1[2] = 16'h3000; v1[3] = 16'hC000;
    v2[0] = 16'h2000; v2[1] = 16'hB000; v2[2] = 16'h1000; v2[3] = 16'hF000;
    nv = rand_vec();
    g = '{v1, v2};
    run_group(0, g, 3, 1'b1, nv, -1);
    g = '{nv, rand_vec()};
    run_group(0, g, -1, 1'b0, '0, -1);

    // Reset mid-drain, then a clean group.
    g = '{rand_vec(), rand_vec()};
    run_group(0, g, -1, 1'b0, '0, 2);
    v1 = {4{16'd5}};
    v2 = {4{16'd1}};
    g = '{v1, v2};
    run_group(0, g, -1, 1'b0, '0, -1);

    // Reset mid-accumulate discards the half-built group.
    send(0, rand_vec(), 0);
    #2 rst = 1'b1;
    #1 check_idle(0, "rst_accum");
    @(posedge clk); #1;
    rst = 1'b0;
    g = '{rand_vec(), rand_vec()};
    run_group(0, g, -1, 1'b0, '0, -1);

    // Randomized groups on a/b.
    hold = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!hold) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        g = '{rand_vec(), rand_vec()};
      end else begin
        g = '{nv, rand_vec()};
      end
      hold_next = (i < 15) && ($urandom_range(0, 2) == 0);
      nv = rand_vec();
      run_group(0, g, -1, hold_next, nv, -1);
      hold = hold_next;
    end

    // Signed extremes on the 3-deep pool.
    v1 = rand_vec(); v2 = rand_vec(); v3 = rand_vec();
    v1[0] = 16'h8000; v2[0] = 16'h7FFF; v3[0] = 16'h7FFF;
    v1[1] = 16'h8000; v2[1] = 16'h8000; v3[1] = 16'h8000;
    g = '{v1, v2, v3};
    run_group(1, g, -1, 1'b0, '0, -1);
    check("ext_ch0", ref_word(g, 0, 1'b0), 16'h7FFF);
    check("ext_ch1", ref_word(g, 1, 1'b0), 16'h8000);

    hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!hold) g = '{rand_vec(), rand_vec(), rand_vec()};
      else       g = '{nv, rand_vec(), rand_vec()};
      hold_next = (i < 7) && ($urandom_range(0, 2) == 0);
      nv = rand_vec();
      run_group(1, g, -1, hold_next, nv, -1);
      hold = hold_next;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
